wb_drain_sequencer: RTL
=======================

WB_DRAIN_SEQUENCER -- requirements
Module: wb_drain_sequencer

Interface
REQ-001 SHALL have parameter NUM_PR, default 64: physical registers; PR_W = $clog2(NUM_PR).
REQ-002 SHALL have parameter DEPTH, default 8: result buffer entries; power of two, at least 4.
REQ-003 SHALL have port f_clk, input, 1: fast clock, 3x core clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port flush, input, 1: synchronous buffer clear.
REQ-006 SHALL have port in_valid, input, [4]: per-lane result present.
REQ-007 SHALL have port in_uses_rd, input, [4]: lane result writes a register.
REQ-008 SHALL have port in_rd, input, [4] x PR_W: destination physical register.
REQ-009 SHALL have port in_data, input, [4] x 32: result data.
REQ-010 SHALL have port in_ready, output, 1: all four lanes may be offered this cycle.
REQ-011 SHALL have port wr_valid, output, [2]: write slot k valid.
REQ-012 SHALL have port wr_rd, output, [2] x PR_W: write address per slot.
REQ-013 SHALL have port wr_data, output, [2] x 32: write data per slot.
REQ-014 SHALL have port phase, output, 2: current slot phase (0, 1 = write; 2 = read).
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1: buffered entries.

Function
REQ-016 SHALL advance phase 0->1->2->0 every f_clk edge; encoding 3 is unreachable.
REQ-017 SHALL drive in_ready = (count <= DEPTH-4), from registered count only.
REQ-018 SHALL enqueue lane i only when in_ready && in_valid[i] && in_uses_rd[i]; lanes failing the valid/uses_rd test are dropped silently.
REQ-019 SHALL compact enqueued lanes in ascending lane order into consecutive FIFO slots; lane 0 is oldest.
REQ-020 SHALL ignore all inputs when in_ready=0; no entry is written and no state changes from inputs.
REQ-021 SHALL drive wr_valid[k] = (phase != 2) && (count > k), combinationally from registered state.
REQ-022 SHALL drive wr_rd[k]/wr_data[k] from FIFO entry head+k; value is don't-care when wr_valid[k]=0.
REQ-023 SHALL pop n_pop = number of asserted wr_valid bits at the edge; head advances by n_pop modulo DEPTH.
REQ-024 SHALL update count = count + n_push - n_pop in the same edge; simultaneous push and pop are legal.
REQ-025 SHALL never present a same-cycle input on wr_*; minimum enqueue-to-write latency is 1 f_clk cycle.
REQ-026 SHALL wrap head and tail pointers modulo DEPTH without bubbles.
REQ-027 SHALL treat an empty FIFO in a write phase as wr_valid=00, with no pop.
REQ-028 SHALL treat count=1 in a write phase as wr_valid=01 and pop one entry.
REQ-029 SHALL, on flush, set head=tail=count=0 at the edge; same-cycle inputs and pops are discarded; phase is unaffected.
REQ-030 SHALL never exceed count=DEPTH; overflow is impossible by construction of REQ-017.
REQ-031 SHALL give two entries with equal rd popped in one phase slot-1 priority by ordering; slot 1 is the younger.

Reset
REQ-032 SHALL, on reset, set phase=0, head=0, tail=0, count=0, in_ready=1, wr_valid=00.
REQ-033 SHALL, on reset asserted mid-operation, discard all buffered entries; reset has priority over flush and inputs.
REQ-034 SHALL leave FIFO data storage unreset.

Verification
REQ-035 SHALL cover reset then 6 idle cycles -> phase sequence 1,2,0,1,2,0; wr_valid=00 throughout; count=0.
REQ-036 SHALL cover phase=2 with in_valid=1111, uses_rd=1111, rd=5,6,7,8 -> count=4. Phase 0 then shows (5,6). Phase 1 then shows (7,8). Count returns to 0.
REQ-037 SHALL cover phase=0 with count=0 and lanes 0,2 valid (rd 3, 9), lane 1 uses_rd=0 -> count=2. Phase 1 then shows wr_rd=(3,9) and wr_valid=11.
REQ-038 SHALL cover count=5, DEPTH=8 -> in_ready=0; offered inputs are dropped; count decrements only by pops.
REQ-039 SHALL cover flush with count=3 and a simultaneous push of 4 -> count=0 next cycle; wr_valid=00; phase continues incrementing.
REQ-040 SHALL cover sustained 2 pushes per cycle for 30 cycles -> head/tail wrap; in-order rd/data on wr_*; in_ready toggles; no entry is lost.

Source files
------------

// File: rtl/wb_drain_sequencer.sv
// wb_drain_sequencer: buffers up to four results per cycle and drains them through
// two register-file write slots during the two write phases of each 3-phase core cycle.
module wb_drain_sequencer #(
  parameter int NUM_PR = 64,
  parameter int DEPTH = 8,
  localparam int PR_W = $clog2(NUM_PR),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                f_clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [3:0]          in_valid,
  input  logic [3:0]          in_uses_rd,
  input  logic [4*PR_W-1:0]   in_rd,
  input  logic [127:0]        in_data,
  output logic                in_ready,
  output logic [1:0]          wr_valid,
  output logic [2*PR_W-1:0]   wr_rd,
  output logic [63:0]         wr_data,
  output logic [1:0]          phase,
  output logic [CW-1:0]       count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {PH_W0 = 2'd0, PH_W1 = 2'd1, PH_RD = 2'd2} phase_t;
  phase_t r_phase;
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [PR_W-1:0] r_rd [DEPTH];
  logic [31:0] r_data [DEPTH];
  logic [3:0] w_push;
  logic [AW-1:0] w_off [4];
  logic [CW-1:0] w_n_push, w_n_pop;
  logic [AW-1:0] w_head1;
  assign in_ready = r_count <= CW'(DEPTH - 4);
  assign w_push = {4{in_ready}} & in_valid & in_uses_rd;
  assign wr_valid[0] = (r_phase != PH_RD) && (r_count != '0);
  assign wr_valid[1] = (r_phase != PH_RD) && (r_count > CW'(1));
  assign w_n_pop = CW'(wr_valid[0]) + CW'(wr_valid[1]);
  assign w_head1 = r_head + AW'(1);
  assign wr_rd = {r_rd[w_head1], r_rd[r_head]};
  assign wr_data = {r_data[w_head1], r_data[r_head]};
  assign phase = r_phase;
  assign count = r_count;
  // Each pushing lane lands after all lower-numbered pushing lanes.
  always_comb begin
    w_n_push = '0;
    for (int i = 0; i < 4; i++) begin
      w_off[i] = w_n_push[AW-1:0];
      w_n_push = w_n_push + CW'(w_push[i]);
    end
  end
  always_ff @(posedge f_clk) begin
    if (reset) begin
      r_phase <= PH_W0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_phase <= r_phase == PH_RD ? PH_W0 : phase_t'(r_phase + 2'd1);
      r_head <= flush ? '0 : r_head + AW'(w_n_pop);
      r_tail <= flush ? '0 : r_tail + AW'(w_n_push);
      r_count <= flush ? '0 : r_count + w_n_push - w_n_pop;
    end
  end
  always_ff @(posedge f_clk) begin
    if (!reset && !flush)
      for (int i = 0; i < 4; i++)
        if (w_push[i]) begin
          r_rd[r_tail + w_off[i]] <= in_rd[i*PR_W +: PR_W];
          r_data[r_tail + w_off[i]] <= in_data[i*32 +: 32];
        end
  end
endmodule
